// File: rtl/modbus_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// modbus_tx_frame_ctrl
//
// Transmit-side framing controller for a Modbus RTU slave. Waits for at least
// GAP_BITS bit times of bus silence, then streams a frame of tx_len_i bytes
// from the TX frame buffer RAM into the UART transmitter back-to-back, keeping
// the RS-485 driver enabled for the whole frame.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   tx_start_i, tx_len_i  frame request (accepted only in IDLE) and length
//   tx_busy_o             frame accepted and not yet finished
//   rd_en_o, rd_addr_o    frame buffer read strobe / byte address
//   rd_data_i             RAM data, valid the cycle after rd_en_o is sampled
//   uart_tx_en_o          one-cycle load pulse for the UART transmitter
//   uart_tx_data_o        byte to send, held until the next load
//   uart_tx_done_i        UART finished a byte (stop bit included)
//   rx_state_i, rx_done_i receiver activity, used for the silence timer
//   rs485_de_o            RS-485 driver enable
//   tx_frame_done_o       one-cycle pulse after the last byte completes
// -----------------------------------------------------------------------------
module modbus_tx_frame_ctrl #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int GAP_BITS  = 35,
  parameter int ADDR_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_start_i,
  input  logic [ADDR_W:0]   tx_len_i,
  output logic              tx_busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              uart_tx_en_o,
  output logic [7:0]        uart_tx_data_o,
  input  logic              uart_tx_done_i,
  input  logic              rx_state_i,
  input  logic              rx_done_i,
  output logic              rs485_de_o,
  output logic              tx_frame_done_o
);

  localparam int BPS     = CLK_FREQ / BAUD_RATE;
  localparam int GAP_CNT = GAP_BITS * BPS;
  localparam int CNT_W   = $clog2(GAP_CNT + 1);

  localparam logic [CNT_W-1:0] GAP_CNT_V = CNT_W'(GAP_CNT);
  localparam logic [ADDR_W:0]  MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_RD,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              de_q, de_d;
  logic              frame_done_q, frame_done_d;

  logic bus_quiet;
  logic is_last;

  assign bus_quiet = (cnt_q == GAP_CNT_V);
  assign is_last   = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

  // Silence timer. Our own transmission (RD/LOAD/WAIT) counts as bus
  // activity, so the gap for a following frame is measured from the last
  // completed byte rather than from the frame request.
  always_comb begin
    cnt_d = cnt_q;
    if (rx_state_i || rx_done_i || uart_tx_done_i ||
        (state_q inside {S_RD, S_LOAD, S_WAIT})) begin
      cnt_d = '0;
    end else if (!bus_quiet) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    de_d         = de_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_start_i && (tx_len_i != '0)) begin
          len_d   = (tx_len_i > MAX_LEN) ? MAX_LEN : tx_len_i;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (bus_quiet) begin
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q;
          de_d      = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        // RAM is sampling the address this cycle; data appears next cycle.
        state_d = S_LOAD;
      end
      S_LOAD: begin
        tx_data_d = rd_data_i;
        tx_en_d   = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (uart_tx_done_i) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q + ADDR_W'(1);
            state_d   = S_RD;
          end
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        de_d         = 1'b0;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of code order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      de_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      de_q         <= de_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_busy_o       = busy_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = rd_addr_q;
  assign uart_tx_en_o    = tx_en_q;
  assign uart_tx_data_o  = tx_data_q;
  assign rs485_de_o      = de_q;
  assign tx_frame_done_o = frame_done_q;

endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modbus_tx_frame_ctrl
//
// Directed bench for modbus_tx_frame_ctrl at CLK_FREQ=1 MHz, BAUD_RATE=100 kHz
// (10 clocks per bit, 350-clock gap). A RAM model answers reads one cycle
// late, a UART model returns uart_tx_done 100 cycles after each load, and a
// negedge monitor logs every rd_en, uart_tx_en, uart_tx_done and
// tx_frame_done with the posedge count at which it appeared.
// -----------------------------------------------------------------------------
module tb_modbus_tx_frame_ctrl;

  localparam int ADDR_W = 8;
  localparam int LOG_N  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_start = 1'b0;
  logic [ADDR_W:0]   tx_len = '0;
  logic              tx_busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = '0;
  logic              uart_tx_en;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_done = 1'b0;
  logic              rx_state = 1'b0;
  logic              rx_done = 1'b0;
  logic              rs485_de;
  logic              tx_frame_done;

  always #5 clk = ~clk;

  modbus_tx_frame_ctrl #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000),
    .GAP_BITS (35),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_start_i     (tx_start),
    .tx_len_i       (tx_len),
    .tx_busy_o      (tx_busy),
    .rd_en_o        (rd_en),
    .rd_addr_o      (rd_addr),
    .rd_data_i      (rd_data),
    .uart_tx_en_o   (uart_tx_en),
    .uart_tx_data_o (uart_tx_data),
    .uart_tx_done_i (uart_tx_done),
    .rx_state_i     (rx_state),
    .rx_done_i      (rx_done),
    .rs485_de_o     (rs485_de),
    .tx_frame_done_o(tx_frame_done)
  );

  // Frame buffer RAM model: one-cycle read latency.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // UART model: byte completes 100 cycles after its load; reset with the DUT.
  int ucnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      ucnt         <= 0;
      uart_tx_done <= 1'b0;
    end else begin
      uart_tx_done <= 1'b0;
      if (uart_tx_en) begin
        ucnt <= 100;
      end else if (ucnt > 0) begin
        ucnt <= ucnt - 1;
        if (ucnt == 1) uart_tx_done <= 1'b1;
      end
    end
  end

  // Posedge counter and event logs.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       rd_cnt = 0, en_cnt = 0, done_cnt = 0, fd_cnt = 0, de_bad = 0;
  int       rd_cyc   [LOG_N];
  int       rd_alog  [LOG_N];
  int       en_cyc   [LOG_N];
  logic [7:0] en_data [LOG_N];
  int       done_cyc [LOG_N];
  int       fd_cyc   [LOG_N];

  always @(negedge clk) begin
    if (rd_en && rd_cnt < LOG_N) begin
      rd_cyc[rd_cnt]  <= cyc;
      rd_alog[rd_cnt] <= int'(rd_addr);
      rd_cnt          <= rd_cnt + 1;
    end
    if (uart_tx_en && en_cnt < LOG_N) begin
      en_cyc[en_cnt]  <= cyc;
      en_data[en_cnt] <= uart_tx_data;
      en_cnt          <= en_cnt + 1;
    end
    if (uart_tx_done && done_cnt < LOG_N) begin
      done_cyc[done_cnt] <= cyc;
      done_cnt           <= done_cnt + 1;
    end
    if (tx_frame_done && fd_cnt < LOG_N) begin
      fd_cyc[fd_cnt] <= cyc;
      fd_cnt         <= fd_cnt + 1;
    end
    if ((uart_tx_en || uart_tx_done) && !rs485_de) de_bad <= de_bad + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // All bench activity happens 1 time unit after a falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_fd(input int base, input int budget, input string tag);
    int n = 0;
    while (fd_cnt == base && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(fd_cnt != base), 32'd1);
  endtask

  task automatic wait_en(input int target, input int budget, input string tag);
    int n = 0;
    while (en_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(en_cnt >= target), 32'd1);
  endtask

  task automatic pulse_start(input int len);
    tx_start = 1'b1;
    tx_len   = (ADDR_W+1)'(len);
    tick(1);
    tx_start = 1'b0;
  endtask

  int r0, e0, d0, f0, t0, bad;
  logic [7:0] frame2 [8];

  initial begin
    frame2 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};

    // ---------------- reset state ----------------
    rst = 1'b1;
    tick(3);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_tx_en", 32'(uart_tx_en), 0);
    check("rst_tx_data", 32'(uart_tx_data), 0);
    check("rst_de", 32'(rs485_de), 0);
    check("rst_fd", 32'(tx_frame_done), 0);

    // ---------------- 1: first frame after reset waits a full gap ----------
    ram[0] = 8'h11;
    r0 = rd_cnt; e0 = en_cnt; d0 = done_cnt; f0 = fd_cnt;
    rst = 1'b0;
    t0  = cyc;
    pulse_start(1);
    check("t1_busy", 32'(tx_busy), 1);
    wait_fd(f0, 2000, "t1_fd_seen");
    check("t1_busy_end", 32'(tx_busy), 0);
    check("t1_de_end", 32'(rs485_de), 0);
    check("t1_rd_lat", 32'(rd_cyc[r0] - t0), 351);
    check("t1_en_lat", 32'(en_cyc[e0] - t0), 353);
    check("t1_loads", 32'(en_cnt - e0), 1);
    check("t1_data", 32'(en_data[e0]), 32'h11);
    check("t1_fd_lat", 32'(fd_cyc[f0] - done_cyc[d0]), 2);
    tick(3);
    check("t1_fd_cnt", 32'(fd_cnt - f0), 1);

    // ---------------- 2: 8-byte frame on a quiet bus ----------------
    for (int i = 0; i < 8; i++) ram[i] = frame2[i];
    tick(400);
    r0 = rd_cnt; e0 = en_cnt; d0 = done_cnt; f0 = fd_cnt;
    t0 = cyc;
    pulse_start(8);
    // Own-echo receiver activity mid-frame must not disturb the frame.
    wait_en(e0 + 1, 50, "t2_first_load");
    tick(20);
    rx_state = 1'b1;
    rx_done  = 1'b1;
    tick(1);
    rx_done  = 1'b0;
    tick(10);
    rx_state = 1'b0;
    wait_fd(f0, 2000, "t2_fd_seen");
    check("t2_rd_lat", 32'(rd_cyc[r0] - t0), 2);
    check("t2_en_lat", 32'(en_cyc[e0] - t0), 4);
    check("t2_loads", 32'(en_cnt - e0), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_data%0d", i), 32'(en_data[e0 + i]), 32'(frame2[i]));
      check($sformatf("t2_addr%0d", i), 32'(rd_alog[r0 + i]), 32'(i));
    end
    for (int i = 1; i < 8; i++)
      check($sformatf("t2_gap%0d", i), 32'(en_cyc[e0 + i] - done_cyc[d0 + i - 1]), 3);
    tick(3);
    check("t2_fd_cnt", 32'(fd_cnt - f0), 1);

    // ---------------- 3: receiver activity restarts the gap ----------------
    r0 = rd_cnt; e0 = en_cnt; f0 = fd_cnt;
    pulse_start(1);
    tick(199);
    rx_state = 1'b1;
    tick(5);
    check("t3_no_rd_early", 32'(rd_cnt - r0), 0);
    rx_state = 1'b0;
    t0 = cyc;
    wait_fd(f0, 2000, "t3_fd_seen");
    check("t3_rd_lat", 32'(rd_cyc[r0] - t0), 351);
    check("t3_data", 32'(en_data[e0]), 32'h01);

    // ---------------- 4: ignored requests ----------------
    tick(400);
    r0 = rd_cnt; e0 = en_cnt; f0 = fd_cnt;
    pulse_start(0);
    tick(20);
    check("t4_len0_busy", 32'(tx_busy), 0);
    check("t4_len0_rd", 32'(rd_cnt - r0), 0);
    pulse_start(2);
    tick(50);
    pulse_start(5);
    wait_fd(f0, 2000, "t4_fd_seen");
    tick(400);
    check("t4_rd", 32'(rd_cnt - r0), 2);
    check("t4_loads", 32'(en_cnt - e0), 2);
    check("t4_fd_cnt", 32'(fd_cnt - f0), 1);
    check("t4_busy", 32'(tx_busy), 0);

    // ---------------- 5: reset mid-frame ----------------
    e0 = en_cnt; f0 = fd_cnt;
    pulse_start(8);
    wait_en(e0 + 3, 2000, "t5_byte3");
    tick(50);
    rst = 1'b1;
    tick(1);
    check("t5_de", 32'(rs485_de), 0);
    check("t5_busy", 32'(tx_busy), 0);
    check("t5_tx_en", 32'(uart_tx_en), 0);
    check("t5_rd_addr", 32'(rd_addr), 0);
    r0 = rd_cnt; e0 = en_cnt;
    rst = 1'b0;
    t0  = cyc;
    pulse_start(1);
    wait_fd(f0, 2000, "t5_fd_seen");
    check("t5_fd_first", 32'(fd_cnt - f0), 1);
    check("t5_rd_lat", 32'(rd_cyc[r0] - t0), 351);
    check("t5_rd_addr0", 32'(rd_alog[r0]), 0);
    check("t5_data", 32'(en_data[e0]), 32'h01);

    // ---------------- 6: oversize length clamps to 256 ----------------
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    tick(400);
    r0 = rd_cnt; e0 = en_cnt; f0 = fd_cnt;
    pulse_start(300);
    wait_fd(f0, 30000, "t6_fd_seen");
    tick(400);
    check("t6_loads", 32'(en_cnt - e0), 256);
    check("t6_rd", 32'(rd_cnt - r0), 256);
    check("t6_fd_cnt", 32'(fd_cnt - f0), 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (rd_alog[r0 + i] != i) bad++;
      if (en_data[e0 + i] != (8'(i) ^ 8'hA5)) bad++;
    end
    check("t6_seq_errs", 32'(bad), 0);
    check("t6_last_addr", 32'(rd_alog[r0 + 255]), 255);

    check("de_window", 32'(de_bad), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/modbus_tx_frame_ctrl.md
Name: modbus_tx_frame_ctrl

Overview:
Transmit-side framing controller for the Modbus RTU slave. It waits until the bus has been silent for at least 3.5 character times, then streams an N-byte response frame from the TX frame buffer RAM into the UART transmitter, one byte at a time with no inter-character gap. It drives the RS-485 driver enable and signals frame completion. It is the transmit counterpart of the receive-side 3.5T frame-boundary detector.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, UART baud rate
GAP_BITS, 35, required inter-frame silence in bit times (3.5 chars x 10 bits)
ADDR_W, 8, frame buffer address width; maximum frame length is 2**ADDR_W bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_start  in  1  one-cycle request to send a frame; sampled only in IDLE
tx_len  in  ADDR_W+1  frame length in bytes; latched with tx_start
tx_busy  out  1  high from the cycle after an accepted tx_start until DONE is left
rd_en  out  1  frame buffer read strobe
rd_addr  out  ADDR_W  frame buffer byte address
rd_data  in  8  RAM read data, valid the cycle after rd_en is sampled
uart_tx_en  out  1  one-cycle pulse that loads the UART transmitter
uart_tx_data  out  8  byte to send; held stable from the uart_tx_en cycle until the next load
uart_tx_done  in  1  one-cycle pulse when the UART finishes a byte, stop bit included
rx_state  in  1  receiver busy (start bit seen, byte in progress)
rx_done  in  1  receiver byte-complete pulse
rs485_de  out  1  RS-485 driver enable
tx_frame_done  out  1  one-cycle pulse when the last byte has completed

Behaviour:
- Derived values: BPS = CLK_FREQ/BAUD_RATE; GAP_CNT = GAP_BITS*BPS. The silence counter width must hold GAP_CNT (24 bits is sufficient at the defaults).
- Silence counter:
  - Cleared to 0 in any cycle where rx_state, rx_done or uart_tx_done is high, or the FSM is in RD, LOAD or WAIT.
  - Otherwise increments, saturating at GAP_CNT.
  - bus_quiet = (cnt == GAP_CNT).
  - Reset value is 0, so the first frame after reset always waits a full gap.
- Reset: state IDLE; tx_busy, rd_en, uart_tx_en, rs485_de and tx_frame_done are 0; rd_addr, uart_tx_data, byte index and latched length are 0; silence counter is 0. Reset mid-frame aborts immediately: rs485_de falls at the reset edge and no tx_frame_done is issued.
- FSM, all outputs registered:
  - IDLE: on tx_start with tx_len != 0, latch the length (tx_len > 2**ADDR_W is clamped to 2**ADDR_W), set index to 0, set tx_busy, go to GAP. tx_start with tx_len == 0 is ignored. tx_start outside IDLE is ignored.
  - GAP: hold until bus_quiet. When quiet: set rd_en=1, rd_addr=index, rs485_de=1, go to RD. Receiver activity during GAP restarts the wait.
  - RD: rd_en=0; go to LOAD.
  - LOAD: set uart_tx_data=rd_data and uart_tx_en=1 for exactly one cycle; go to WAIT.
  - WAIT: on uart_tx_done:
    - if index == len-1, go to DONE;
    - else increment index, set rd_en=1 and rd_addr=index+1, go to RD.
  - DONE: tx_frame_done=1 for one cycle, rs485_de=0, tx_busy=0; go to IDLE.
- Latency with bus already quiet: tx_start sampled at edge k gives rd_en high after edge k+1 and uart_tx_en high after edge k+3. Between bytes, the next uart_tx_en is 3 cycles after uart_tx_done.
- rx_state and rx_done during RD, LOAD or WAIT (own echo) do not alter the frame; they only keep the counter cleared.
- A uart_tx_done outside WAIT is ignored by the FSM; it still clears the counter.
- Back-to-back frames: the counter restarts from 0 after DONE, so the next frame waits a full GAP_CNT after its last uart_tx_done.

Test Plan:
Bench uses CLK_FREQ=1000000, BAUD_RATE=100000, so BPS=10 and GAP_CNT=350; UART model returns uart_tx_done 100 cycles after each uart_tx_en.
1. Start immediately after reset, tx_len=1, RAM[0]=0x11 -> rd_en first high 351 cycles after reset release; one uart_tx_en with data 0x11; tx_frame_done 2 cycles after uart_tx_done; rs485_de covers that window.
2. Bus idle for more than 350 cycles, tx_len=8, RAM = 01 03 00 00 00 0A C5 CD -> uart_tx_en 3 cycles after tx_start; 8 bytes sent in order, each load 3 cycles after the previous uart_tx_done; exactly one tx_frame_done.
3. rx_state pulses at cycle 200 of the gap wait -> rd_en delayed until 350 quiet cycles after rx_state falls.
4. tx_start with tx_len=0, and tx_start while tx_busy -> no rd_en, no uart_tx_en, no tx_frame_done; the in-flight frame is unaffected.
5. rst asserted during byte 3 of 8 -> on the next edge rs485_de=0, tx_busy=0, uart_tx_en=0; no tx_frame_done; a new frame waits a full 350-cycle gap.
6. tx_len=300 with ADDR_W=8 -> exactly 256 bytes sent, rd_addr 0..255, no wrap.
